gate_tt_checker: RTL and testbench
==================================

# gate_tt_checker

Sequential truth-table checker for the 2-input gate library. It drives the shared inputs `i1`/`i2` of one AND2 and one OR2 instance through all four input vectors and waits a programmable settle time per vector. It then samples both gate outputs, compares them against the expected AND/OR tables and reports a captured truth table plus pass/fail. It is the stimulus/response end of the gate interface and sits beside the gates as a built-in self-test.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `i1`/`i2` are held before sampling. Legal range is 1..15; 0 is illegal.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  begin a sweep; sampled only in IDLE
- `i1`  output  1  stimulus to both gates' `i1`
- `i2`  output  1  stimulus to both gates' `i2`
- `and_o`  input  1  AND2 output under test
- `or_o`  input  1  OR2 output under test
- `busy`  output  1  high from the cycle after start acceptance through FINISH
- `done`  output  1  one-cycle pulse in FINISH
- `pass`  output  1  result, valid from `done` until the next accepted start
- `fail_vec`  output  4  bit k set if vector k mismatched on either gate
- `and_tt`  output  4  captured AND output, bit k = vector k
- `or_tt`  output  4  captured OR output, bit k = vector k

## Operation
- Vector index k is 2 bits: `i1` = k[1], `i2` = k[0]. The sweep order is 0, 1, 2, 3.
- Expected values: AND table 4'b1000, OR table 4'b1110.
- States:
  - IDLE: `i1`/`i2` = 0, `busy` = 0. On `start`: clear `fail_vec`/`and_tt`/`or_tt`, `pass` <= 0, k <= 0, cnt <= 0, go to SETTLE.
  - SETTLE: `i1`/`i2` driven from k; cnt increments. When cnt == SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: `i1`/`i2` still driven from k. Capture `and_tt`[k] <= `and_o` and `or_tt`[k] <= `or_o`. Set `fail_vec`[k] on any mismatch. If k == 3, go to FINISH; else k++, cnt <= 0, go to SETTLE.
  - FINISH: `done` = 1, `pass` <= ~|`fail_vec` (including the bit just captured), go to IDLE.
- `start` in any state other than IDLE is ignored, with no queuing.
- `start` held high continuously: a new sweep begins on the first IDLE cycle after FINISH.
- Reset values: `i1`/`i2`/`busy`/`done`/`pass` = 0, `fail_vec`/`and_tt`/`or_tt` = 0, state IDLE.
- Reset asserted mid-sweep: every output returns to its reset value immediately (asynchronously). No partial result is retained.
- X/Z on `and_o`/`or_o` is not handled; the bench drives clean levels.

## Timing
- Per vector: SETTLE_CYCLES + 1 cycles.
- `start` accepted at edge T:
  - vector 0 is driven from cycle T+1;
  - vector k is sampled at T+(k+1)(S+1);
  - `done` is high in cycle T+4(S+1)+1, which is T+13 for S=2.
- `i1`/`i2` change only on the SETTLE entry edge, so they are glitch-free and registered-derived.
- `busy` falls in the cycle after `done`. The earliest next start acceptance is that same IDLE cycle.

## Configuration
- `GATE_CHK_STOP_ON_FAIL_EN`
  - Defined: SAMPLE with any mismatch goes directly to FINISH. Untested vectors keep 0 in `fail_vec`/`and_tt`/`or_tt`, and `pass` = 0.
  - Undefined: all four vectors always run, and latency is fixed at 4(S+1)+1.

## Structure
- Package `gate_chk_pkg`: state enum (IDLE, SETTLE, SAMPLE, FINISH), `NUM_VEC` = 4, `EXP_AND_TT` = 4'b1000, `EXP_OR_TT` = 4'b1110.
- Sub-module `gate_chk_timer`: settle down-counter with load/expire, parameterised by SETTLE_CYCLES.
- The FSM, capture registers and comparison stay in the top level.

## Test plan
- Real AND2/OR2 connected, S=2, `start` pulse at T → `i1i2` sequence 00,01,10,11, each held 3 cycles; `done` at T+13; `pass`=1, `and_tt`=4'b1000, `or_tt`=4'b1110, `fail_vec`=0.
- `and_o` stuck at 0, macro undefined → `done` at T+13, `and_tt`=4'b0000, `fail_vec`=4'b1000, `pass`=0.
- `or_o` stuck at 1 with `GATE_CHK_STOP_ON_FAIL_EN`, S=2 → `done` at T+4, `or_tt`=4'b0001, `fail_vec`=4'b0001, `and_tt`=0, `pass`=0.
- `start` re-pulsed at T+5 during a sweep → ignored; `done` still at T+13 and exactly one `done` pulse.
- `rst_n` low at T+7 for 2 cycles → all outputs 0 immediately, state IDLE; a new start after release gives a full, correct sweep.
- S=1 → `done` at T+9, each vector held 2 cycles, results identical to the first scenario.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } chk_state_t;

    localparam int unsigned NUM_VEC = 4;

    typedef logic [1:0] vec_idx_t;

    localparam logic [NUM_VEC-1:0] EXP_AND_TT = 4'b1000;
    localparam logic [NUM_VEC-1:0] EXP_OR_TT  = 4'b1110;

endpackage

// File: rtl/gate_tt_checker_if.sv
// Stimulus/response bundle between the checker (master) and the gates under test (slave).
interface gate_tt_checker_if;

    logic i1;
    logic i2;
    logic and_o;
    logic or_o;

    modport master (
        output i1,
        output i2,
        input  and_o,
        input  or_o
    );

    modport slave (
        input  i1,
        input  i2,
        output and_o,
        output or_o
    );

endinterface

// File: rtl/gate_chk_timer.sv
// Settle-time down-counter: load arms it, en counts down, expire flags the last settle cycle.
module gate_chk_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= 4'(SETTLE_CYCLES - 1);
        end else if (en && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Built-in self-test sweeping an AND2/OR2 pair through all four input vectors.
// Optional `GATE_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    gate_tt_checker_if.master        gate,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [NUM_VEC-1:0]       fail_vec,
    output logic [NUM_VEC-1:0]       and_tt,
    output logic [NUM_VEC-1:0]       or_tt
);

    chk_state_t state, state_nxt;
    vec_idx_t   k_q;
    vec_idx_t   drv_q;
    logic       timer_load;
    logic       timer_en;
    logic       timer_expire;
    logic       vec_fail;
    logic       stop_early;

    gate_chk_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (timer_en),
        .expire (timer_expire)
    );

    assign vec_fail = (gate.and_o != EXP_AND_TT[k_q]) || (gate.or_o != EXP_OR_TT[k_q]);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    assign stop_early = vec_fail;
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SETTLE;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                timer_en = 1'b1;
                if (timer_expire) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if ((k_q == vec_idx_t'(NUM_VEC - 1)) || stop_early) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt  = SETTLE;
                    timer_load = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // pass is resolved on the edge into FINISH so it is already valid while done is high;
    // the drive register is cleared on that same edge so i1/i2 idle at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            drv_q    <= '0;
            fail_vec <= '0;
            and_tt   <= '0;
            or_tt    <= '0;
            pass     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_q      <= '0;
                        drv_q    <= '0;
                        fail_vec <= '0;
                        and_tt   <= '0;
                        or_tt    <= '0;
                        pass     <= 1'b0;
                    end
                end
                SAMPLE: begin
                    and_tt[k_q] <= gate.and_o;
                    or_tt[k_q]  <= gate.or_o;
                    if (vec_fail) begin
                        fail_vec[k_q] <= 1'b1;
                    end
                    if (state_nxt == FINISH) begin
                        pass  <= ~((|fail_vec) | vec_fail);
                        drv_q <= '0;
                    end else begin
                        k_q   <= k_q + 2'd1;
                        drv_q <= k_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gate.i1 = drv_q[1];
    assign gate.i2 = drv_q[0];
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: S=2 and S=1 instances driving behavioural AND2/OR2 models.
module tb_gate_tt_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;
    logic and_stuck0, or_stuck1;

    gate_tt_checker_if gif_a ();
    gate_tt_checker_if gif_b ();

    assign gif_a.and_o = and_stuck0 ? 1'b0 : (gif_a.i1 & gif_a.i2);
    assign gif_a.or_o  = or_stuck1  ? 1'b1 : (gif_a.i1 | gif_a.i2);
    assign gif_b.and_o = gif_b.i1 & gif_b.i2;
    assign gif_b.or_o  = gif_b.i1 | gif_b.i2;

    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [3:0] fail_a, and_a, or_a, fail_b, and_b, or_b;

    gate_tt_checker #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .gate(gif_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_vec(fail_a), .and_tt(and_a), .or_tt(or_a)
    );

    gate_tt_checker #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .gate(gif_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_vec(fail_b), .and_tt(and_b), .or_tt(or_b)
    );

    // Monitor mux so one sweep task serves both instances.
    logic       sel;
    logic       m_i1, m_i2, m_busy, m_done, m_pass;
    logic [3:0] m_fail, m_and, m_or;
    assign m_i1   = sel ? gif_b.i1 : gif_a.i1;
    assign m_i2   = sel ? gif_b.i2 : gif_a.i2;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_pass = sel ? pass_b : pass_a;
    assign m_fail = sel ? fail_b : fail_a;
    assign m_and  = sel ? and_b  : and_a;
    assign m_or   = sel ? or_b   : or_a;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic which, input logic v);
        if (which) start_b = v;
        else       start_a = v;
    endtask

    // Pulses start, then observes 20 cycles: cycle c is the c-th negedge after the accepting edge.
    task automatic sweep(input logic which, input int s, input int repulse_at,
                         output int done_at, output int done_cnt, output int vec_err,
                         output logic pass_at_done);
        int exp_v;
        sel = which;
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        done_at = -1; done_cnt = 0; vec_err = 0; pass_at_done = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(negedge clk);
                set_start(which, c == repulse_at);
            end
            if (m_done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at      = c;
                    pass_at_done = m_pass;
                end
                if ({m_i1, m_i2} != 2'b00 || !m_busy) vec_err++;
            end else if (done_at < 0) begin
                exp_v = (c - 1) / (s + 1);
                if (int'({m_i1, m_i2}) != exp_v || !m_busy) vec_err++;
            end else if (m_busy || {m_i1, m_i2} != 2'b00) begin
                vec_err++;
            end
        end
        set_start(which, 1'b0);
    endtask

    typedef struct {
        string      name;
        logic       and_s0;
        logic       or_s1;
        int         exp_done;
        logic [3:0] exp_and;
        logic [3:0] exp_or;
        logic [3:0] exp_fail;
        logic       exp_pass;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int   d_at, d_cnt, v_err;
        logic p_done;

        tbl[0] = '{"good",      1'b0, 1'b0, 13, 4'b1000, 4'b1110, 4'b0000, 1'b1};
        tbl[1] = '{"and_s0",    1'b1, 1'b0, 13, 4'b0000, 4'b1110, 4'b1000, 1'b0};
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        tbl[2] = '{"or_s1",     1'b0, 1'b1,  4, 4'b0000, 4'b0001, 4'b0001, 1'b0};
        tbl[3] = '{"both",      1'b1, 1'b1,  4, 4'b0000, 4'b0001, 4'b0001, 1'b0};
`else
        tbl[2] = '{"or_s1",     1'b0, 1'b1, 13, 4'b1000, 4'b1111, 4'b0001, 1'b0};
        tbl[3] = '{"both",      1'b1, 1'b1, 13, 4'b0000, 4'b1111, 4'b1001, 1'b0};
`endif

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        and_stuck0 = 1'b0; or_stuck1 = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_a", {busy_a, done_a, pass_a, fail_a, and_a, or_a, gif_a.i1, gif_a.i2}, '0);
        chk("reset_b", {busy_b, done_b, pass_b, fail_b, and_b, or_b, gif_b.i1, gif_b.i2}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            and_stuck0 = tbl[r].and_s0;
            or_stuck1  = tbl[r].or_s1;
            sweep(1'b0, 2, -1, d_at, d_cnt, v_err, p_done);
            chk({tbl[r].name, "_done_at"},  d_at,   tbl[r].exp_done);
            chk({tbl[r].name, "_done_cnt"}, d_cnt,  1);
            chk({tbl[r].name, "_drive"},    v_err,  0);
            chk({tbl[r].name, "_pass"},     p_done, tbl[r].exp_pass);
            chk({tbl[r].name, "_and_tt"},   m_and,  tbl[r].exp_and);
            chk({tbl[r].name, "_or_tt"},    m_or,   tbl[r].exp_or);
            chk({tbl[r].name, "_fail_vec"}, m_fail, tbl[r].exp_fail);
        end
        and_stuck0 = 1'b0;
        or_stuck1  = 1'b0;

        // start re-pulsed mid-sweep is ignored
        sweep(1'b0, 2, 5, d_at, d_cnt, v_err, p_done);
        chk("repulse_done_at",  d_at,  13);
        chk("repulse_done_cnt", d_cnt, 1);
        chk("repulse_drive",    v_err, 0);
        chk("repulse_pass",     p_done, 1'b1);

        // asynchronous reset at T+7
        sel = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy",  busy_a, 1'b1);
        chk("pre_rst_or_tt", or_a,   4'b0010);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busy_a, done_a, pass_a, fail_a, and_a, or_a, gif_a.i1, gif_a.i2}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {busy_a, done_a, gif_a.i1, gif_a.i2}, '0);
        sweep(1'b0, 2, -1, d_at, d_cnt, v_err, p_done);
        chk("post_rst_done_at", d_at, 13);
        chk("post_rst_drive",   v_err, 0);
        chk("post_rst_results", {p_done, m_and, m_or, m_fail}, {1'b1, 4'b1000, 4'b1110, 4'b0000});

        // S=1 instance
        sweep(1'b1, 1, -1, d_at, d_cnt, v_err, p_done);
        chk("s1_done_at",  d_at,  9);
        chk("s1_done_cnt", d_cnt, 1);
        chk("s1_drive",    v_err, 0);
        chk("s1_results",  {p_done, m_and, m_or, m_fail}, {1'b1, 4'b1000, 4'b1110, 4'b0000});

        // start held high: back-to-back sweeps with a single IDLE cycle between
        begin
            int first_done, second_done, idle_gap_busy;
            sel = 1'b0;
            first_done = -1; second_done = -1; idle_gap_busy = -1;
            @(negedge clk); start_a = 1'b1;
            for (int c = 1; c <= 27; c++) begin
                @(negedge clk);
                if (done_a) begin
                    if (first_done < 0) first_done = c;
                    else if (second_done < 0) second_done = c;
                end
                if (first_done > 0 && c == first_done + 1) idle_gap_busy = int'(busy_a);
            end
            start_a = 1'b0;
            chk("held_first_done",  first_done,  13);
            chk("held_idle_gap",    idle_gap_busy, 0);
            chk("held_second_done", second_done, 27);
            for (int c = 0; c < 20 && busy_a; c++) @(negedge clk);
            chk("held_final_idle", busy_a, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
